// File: rtl/icache_mshr_txreq_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_mshr_txreq_arb_pkg
// Description : Shared types and constants for the I-cache MSHR downstream
//               request arbiter: request payload, response sideband, default
//               sizing and the round-robin pointer advance helper.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_mshr_txreq_arb_pkg;

   // Default sizing. The transaction ID is the MSHR entry index, so its
   // width is derived from the entry count rather than chosen freely.
   localparam int TXARB_ENTRY_NUM  = 4;
   localparam int TXARB_ID_W       = (TXARB_ENTRY_NUM > 1) ? $clog2(TXARB_ENTRY_NUM) : 1;
   localparam int TXARB_LINE_BEATS = 4;
   localparam int TXARB_BEAT_CNT_W = (TXARB_LINE_BEATS > 1) ? $clog2(TXARB_LINE_BEATS) : 1;

   // Downstream read request payload issued by an MSHR entry.
   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  prot;
   } pc_req_t;

   // Response sideband used to route a beat back to its owning entry.
   typedef struct packed {
      logic [TXARB_ID_W-1:0] id;
      logic                  last;
   } ds_rsp_t;

   // Next round-robin start index: one past the winner, wrapping to 0.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/icache_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : icache_rr_arb
// Description : Combinational round-robin priority search. Grants the first
//               eligible index at or after rr_ptr, searching upward with
//               wrap-around.
// Ports       : eligible  in  N      request mask
//               rr_ptr    in  IDX_W  search start index (must be < N)
//               grant_oh  out N      one-hot grant, zero when nothing eligible
//               grant_idx out IDX_W  binary index of the grant
//               any_grant out 1      at least one index eligible
// Revision    : 1.0 - initial release
// ============================================================================
module icache_rr_arb #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     eligible,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N-1:0]     grant_oh,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_grant
);

   // One extra bit so rr_ptr + k cannot overflow before the wrap compare.
   logic [IDX_W:0]   probe_sum;
   logic [IDX_W-1:0] probe_idx;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      probe_sum = '0;
      probe_idx = '0;
      for (int k = 0; k < N; k++) begin
         probe_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (probe_sum >= (IDX_W+1)'(N)) begin
            probe_sum = probe_sum - (IDX_W+1)'(N);
         end
         probe_idx = probe_sum[IDX_W-1:0];
         if (!any_grant && eligible[probe_idx]) begin
            any_grant           = 1'b1;
            grant_idx           = probe_idx;
            grant_oh[probe_idx] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/icache_mshr_txreq_arb.sv
`default_nettype none
// ============================================================================
// Module      : icache_mshr_txreq_arb
// Description : Round-robin arbiter between the MSHR entries and a single
//               registered downstream read-request channel. Tracks which
//               entries are in flight, counts response beats per entry and
//               pulses linefill_done to the owner on the last beat.
// Ports       : clk, rst_n                 clock, synchronous active-low reset
//               entry_txreq_vld/rdy/pld    per-entry request handshake
//               downstream_txreq_vld/rdy   registered request channel
//               downstream_txreq_pld/id    registered payload, entry index ID
//               downstream_rxrsp_vld/rdy   response beats (rdy tied high)
//               downstream_rxrsp_id/last   response routing
//               linefill_done              one-cycle done pulse per entry
//               inflight_bitmap            entries awaiting their last beat
//               rsp_err                    sticky response protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module icache_mshr_txreq_arb
   import icache_mshr_txreq_arb_pkg::*;
#(
   parameter int MSHR_ENTRY_NUM = TXARB_ENTRY_NUM,
   parameter int ID_W           = TXARB_ID_W,
   parameter int LINE_BEATS     = TXARB_LINE_BEATS,
   parameter int BEAT_CNT_W     = TXARB_BEAT_CNT_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [MSHR_ENTRY_NUM-1:0] entry_txreq_vld,
   output logic [MSHR_ENTRY_NUM-1:0] entry_txreq_rdy,
   input  pc_req_t                   entry_txreq_pld [MSHR_ENTRY_NUM],
   output logic                      downstream_txreq_vld,
   input  logic                      downstream_txreq_rdy,
   output pc_req_t                   downstream_txreq_pld,
   output logic [ID_W-1:0]           downstream_txreq_id,
   input  logic                      downstream_rxrsp_vld,
   output logic                      downstream_rxrsp_rdy,
   input  logic [ID_W-1:0]           downstream_rxrsp_id,
   input  logic                      downstream_rxrsp_last,
   output logic [MSHR_ENTRY_NUM-1:0] linefill_done,
   output logic [MSHR_ENTRY_NUM-1:0] inflight_bitmap,
   output logic                      rsp_err
);

   localparam logic [BEAT_CNT_W-1:0] LAST_BEAT_CNT = BEAT_CNT_W'(LINE_BEATS - 1);

   logic [MSHR_ENTRY_NUM-1:0] inflight;
   logic [ID_W-1:0]           rr_ptr;
   logic [BEAT_CNT_W-1:0]     beat_cnt [MSHR_ENTRY_NUM];

   logic [MSHR_ENTRY_NUM-1:0] eligible;
   logic [MSHR_ENTRY_NUM-1:0] grant_oh;
   logic [ID_W-1:0]           grant_idx;
   logic                      any_grant;
   logic                      load;
   logic [MSHR_ENTRY_NUM-1:0] set_mask;
   logic [MSHR_ENTRY_NUM-1:0] clr_mask;
   logic [MSHR_ENTRY_NUM-1:0] beat_hit;

   ds_rsp_t                   rsp;
   logic                      rsp_hit;
   logic [BEAT_CNT_W-1:0]     rsp_cnt;
   logic                      err_orphan;
   logic                      err_early_last;
   logic                      err_overrun;

   // ------------------------------------------------------------------------
   // Request side
   // ------------------------------------------------------------------------
   // The registered inflight mask is used, so an entry whose last beat
   // arrives this cycle stays masked until the following cycle.
   assign eligible = entry_txreq_vld & ~inflight;

   icache_rr_arb #(
      .N     (MSHR_ENTRY_NUM),
      .IDX_W (ID_W)
   ) u_rr_arb (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // rst_n is folded in so an entry never sees an accept that reset discards.
   assign load            = any_grant & (~downstream_txreq_vld | downstream_txreq_rdy) & rst_n;
   assign entry_txreq_rdy = grant_oh & {MSHR_ENTRY_NUM{load}};
   assign set_mask        = entry_txreq_rdy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         downstream_txreq_vld <= 1'b0;
         downstream_txreq_pld <= '0;
         downstream_txreq_id  <= '0;
         rr_ptr               <= '0;
      end else if (load) begin
         downstream_txreq_vld <= 1'b1;
         downstream_txreq_pld <= entry_txreq_pld[grant_idx];
         downstream_txreq_id  <= grant_idx;
         rr_ptr               <= ID_W'(rr_next(int'(grant_idx), MSHR_ENTRY_NUM));
      end else if (downstream_txreq_rdy) begin
         downstream_txreq_vld <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Response side
   // ------------------------------------------------------------------------
   assign downstream_rxrsp_rdy = 1'b1;

   assign rsp.id   = TXARB_ID_W'(downstream_rxrsp_id);
   assign rsp.last = downstream_rxrsp_last;

   assign rsp_hit        = downstream_rxrsp_vld & inflight[rsp.id];
   assign rsp_cnt        = beat_cnt[rsp.id];
   assign err_orphan     = downstream_rxrsp_vld & ~inflight[rsp.id];
   assign err_early_last = rsp_hit &  rsp.last & (rsp_cnt != LAST_BEAT_CNT);
   assign err_overrun    = rsp_hit & ~rsp.last & (rsp_cnt == LAST_BEAT_CNT);

   // Per-entry decode of the response beat and its beat counter. The counter
   // saturates on an overrun so a runaway burst cannot alias to a fresh line.
   for (genvar gi = 0; gi < MSHR_ENTRY_NUM; gi++) begin : g_entry
      assign beat_hit[gi] = rsp_hit & (rsp.id == TXARB_ID_W'(gi));
      assign clr_mask[gi] = beat_hit[gi] & rsp.last;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            beat_cnt[gi] <= '0;
         end else if (clr_mask[gi]) begin
            beat_cnt[gi] <= '0;
         end else if (beat_hit[gi] && (beat_cnt[gi] != LAST_BEAT_CNT)) begin
            beat_cnt[gi] <= beat_cnt[gi] + BEAT_CNT_W'(1);
         end
      end
   end

   // Set and clear never target the same entry: a set entry was not in
   // flight, while a clear needs the entry to be in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight      <= '0;
         linefill_done <= '0;
         rsp_err       <= 1'b0;
      end else begin
         inflight      <= (inflight | set_mask) & ~clr_mask;
         linefill_done <= clr_mask;
         if (err_orphan || err_early_last || err_overrun) begin
            rsp_err <= 1'b1;
         end
      end
   end

   assign inflight_bitmap = inflight;

endmodule
`default_nettype wire
